// File: rtl/pwm_ramp_sequencer.sv
// Duty-ramp sequencer for a shared PWM generator: slews the duty toward a clamped target and
// ramps to zero before switching the active device, so the output mux only changes at zero duty.
module pwm_ramp_sequencer #(
   parameter int DUTY_W    = 19,
   parameter int DUTY_MAX  = 500000,
   parameter int DUTY_STEP = 1000,
   parameter int STEP_DIV  = 50000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DUTY_W-1:0] DUTY_TGT,
   input  logic [1:0]        SEL_REQ,
   input  logic              SEL_VALID,
   output logic [DUTY_W-1:0] DUTY_OUT,
   output logic [1:0]        SEL_ACT,
   output logic              BUSY,
   output logic              SWITCH_DONE
);

   localparam int                CNT_W    = $clog2(STEP_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_DIV - 1);
   localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] STEP_D   = DUTY_W'(DUTY_STEP);

   localparam logic [1:0] RUN       = 2'd0;
   localparam logic [1:0] RAMP_DOWN = 2'd1;
   localparam logic [1:0] SWITCH    = 2'd2;

   logic [1:0]        state;
   logic [1:0]        sel_pend;
   logic [1:0]        hold_req;
   logic              hold_vld;
   logic [CNT_W-1:0]  cnt;
   logic              tick;
   logic [DUTY_W-1:0] tgt;
   logic [DUTY_W-1:0] duty_up;
   logic [DUTY_W-1:0] duty_dn;
   logic              req_vld;
   logic [1:0]        req_sel;

   assign tick        = (cnt == CNT_LAST);
   assign BUSY        = (state != RUN);
   assign SWITCH_DONE = (state == SWITCH);

   // A request caught during SWITCH is replayed in the first RUN cycle; a live strobe there wins.
   assign req_vld = SEL_VALID | hold_vld;
   assign req_sel = SEL_VALID ? SEL_REQ : hold_req;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

   always_comb begin
      tgt = '0;
      if (SEL_ACT != 2'b00) tgt = (DUTY_TGT > MAX_D) ? MAX_D : DUTY_TGT;
   end

   // Differences are taken in the safe direction only, so neither step can wrap.
   always_comb begin
      duty_up = DUTY_OUT;
      if (tgt > DUTY_OUT)
         duty_up = ((tgt - DUTY_OUT) <= STEP_D) ? tgt : DUTY_OUT + STEP_D;
      else if (tgt < DUTY_OUT)
         duty_up = ((DUTY_OUT - tgt) <= STEP_D) ? tgt : DUTY_OUT - STEP_D;
   end

   assign duty_dn = (DUTY_OUT <= STEP_D) ? '0 : DUTY_OUT - STEP_D;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= RUN;
         DUTY_OUT <= '0;
         SEL_ACT  <= 2'b00;
         sel_pend <= 2'b00;
         hold_req <= 2'b00;
         hold_vld <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               hold_vld <= 1'b0;
               if (tick) DUTY_OUT <= duty_up;
               if (req_vld && (req_sel != SEL_ACT)) begin
                  sel_pend <= req_sel;
                  state    <= RAMP_DOWN;
               end
            end
            RAMP_DOWN: begin
               if (tick)           DUTY_OUT <= duty_dn;
               if (SEL_VALID)      sel_pend <= SEL_REQ;
               if (DUTY_OUT == '0) state    <= SWITCH;
            end
            SWITCH: begin
               DUTY_OUT <= '0;
               SEL_ACT  <= sel_pend;
               state    <= RUN;
               if (SEL_VALID) begin
                  hold_vld <= 1'b1;
                  hold_req <= SEL_REQ;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
